// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, parity and
// stop-bit codes, and small decode helpers used when a frame's settings are latched.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak,
    StBrkStop
  } txState_e;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic [1:0] STOP_ONE     = 2'd0;
  localparam logic [1:0] STOP_ONEHALF = 2'd1;
  localparam logic [1:0] STOP_TWO     = 2'd2;

  // Data bits per frame; anything outside 5..9 falls back to 8.
  function automatic logic [3:0] decodeDataBits(input logic [3:0] bits);
    return (bits >= 4'd5 && bits <= 4'd9) ? bits : 4'd8;
  endfunction

  function automatic logic parityEnabled(input logic [2:0] par);
    return (par >= PAR_ODD) && (par <= PAR_SPACE);
  endfunction

  // Parity bit from the XOR of all data bits sent.
  function automatic logic parityBit(input logic [2:0] par, input logic dataXor);
    logic pb;
    case (par)
      PAR_ODD:  pb = ~dataXor;
      PAR_EVEN: pb = dataXor;
      PAR_MARK: pb = 1'b1;
      default:  pb = 1'b0;
    endcase
    return pb;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the UART TX path.
// Ports:
//   CLK, RESETn       clock, asynchronous active-low reset
//   Push, PushData    write strobe and data
//   Pop               read strobe; PopData shows the head entry combinationally
//   Clr               synchronous flush, wins over a same-cycle Push
//   Full, Empty       registered flags
//   Level             registered entry count
//   Overflow          one-cycle pulse when a Push was dropped
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 9
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     Push,
  input  logic [DW-1:0]            PushData,
  input  logic                     Pop,
  input  logic                     Clr,
  output logic [DW-1:0]            PopData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LevelMax = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [AW:0]   levelQ, levelD;
  logic          fullQ, emptyQ, overflowQ, overflowD;
  logic          doPush, doPop;

  always_comb begin
    doPop     = Pop & ~emptyQ;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    doPush    = Push & ~Clr & (~fullQ | doPop);
    overflowD = Push & ~Clr & ~doPush;
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    levelD    = levelQ;
    if (Clr) begin
      wrPtrD = '0;
      rdPtrD = '0;
      levelD = '0;
    end else begin
      if (doPush) wrPtrD = wrPtrQ + 1'b1;
      if (doPop)  rdPtrD = rdPtrQ + 1'b1;
      if (doPush && !doPop)      levelD = levelQ + 1'b1;
      else if (doPop && !doPush) levelD = levelQ - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      levelQ    <= '0;
      fullQ     <= 1'b0;
      emptyQ    <= 1'b1;
      overflowQ <= 1'b0;
    end else begin
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      levelQ    <= levelD;
      fullQ     <= (levelD == LevelMax);
      emptyQ    <= (levelD == '0);
      overflowQ <= overflowD;
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtrQ] <= PushData;
  end

  assign PopData  = mem[rdPtrQ];
  assign Full     = fullQ;
  assign Empty    = emptyQ;
  assign Level    = levelQ;
  assign Overflow = overflowQ;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: TX FIFO, framing FSM, CTS gating and break generation.
// Ports:
//   CLK, RESETn            clock, asynchronous active-low reset
//   BaudTick               one-CLK pulse at OSR x baud
//   TxEn                   transmitter enable; low forces IDLE immediately
//   DataBits/Parity/StopBits  frame format, latched at frame start
//   CtsEn, CTSn            optional clear-to-send gating of frame start
//   BreakReq               level request to hold TXD low
//   WrEn, WrData, FifoClr  FIFO write side and flush
//   FifoFull/FifoEmpty/FifoLevel/Overflow  FIFO status
//   TXD                    serial output, idle high
//   TxBusy, TxDone         FSM not idle; pulse at end of a frame's last stop bit
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OSR        = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DW         = 9
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          BaudTick,
  input  logic                          TxEn,
  input  logic [3:0]                    DataBits,
  input  logic [2:0]                    Parity,
  input  logic [1:0]                    StopBits,
  input  logic                          CtsEn,
  input  logic                          CTSn,
  input  logic                          BreakReq,
  input  logic                          WrEn,
  input  logic [DW-1:0]                 WrData,
  input  logic                          FifoClr,
  output logic                          FifoFull,
  output logic                          FifoEmpty,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
  output logic                          Overflow,
  output logic                          TXD,
  output logic                          TxBusy,
  output logic                          TxDone
);

  localparam int unsigned TW = $clog2(2 * OSR);
  localparam logic [TW-1:0] BitLoad     = TW'(OSR - 1);
  localparam logic [TW-1:0] OneHalfLoad = TW'(OSR * 3 / 2 - 1);
  localparam logic [TW-1:0] TwoLoad     = TW'(2 * OSR - 1);

  txState_e      stateQ, stateD;
  logic [TW-1:0] timerQ, timerD, stopLoad;
  logic [3:0]    bitCntQ, bitCntD;
  logic [DW-1:0] shiftQ, shiftD;
  logic          parAccQ, parAccD;
  logic [3:0]    cfgBitsQ, cfgBitsD;
  logic [2:0]    cfgParQ, cfgParD;
  logic [1:0]    cfgStopQ, cfgStopD;
  logic          txdQ, txdD;
  logic          doneQ, doneD;
  logic          ctsMetaQ, ctsSyncQ;
  logic          fifoPop, launch, startOk, bitEnd, lastXor;
  logic [DW-1:0] fifoRdData;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Push     (WrEn),
    .PushData (WrData),
    .Pop      (fifoPop),
    .Clr      (FifoClr),
    .PopData  (fifoRdData),
    .Full     (FifoFull),
    .Empty    (FifoEmpty),
    .Level    (FifoLevel),
    .Overflow (Overflow)
  );

  always_comb begin
    case (cfgStopQ)
      STOP_ONE:     stopLoad = BitLoad;
      STOP_ONEHALF: stopLoad = OneHalfLoad;
      default:      stopLoad = TwoLoad;
    endcase
  end

  always_comb begin
    stateD   = stateQ;
    timerD   = timerQ;
    bitCntD  = bitCntQ;
    shiftD   = shiftQ;
    parAccD  = parAccQ;
    cfgBitsD = cfgBitsQ;
    cfgParD  = cfgParQ;
    cfgStopD = cfgStopQ;
    txdD     = txdQ;
    doneD    = 1'b0;
    fifoPop  = 1'b0;
    launch   = 1'b0;
    lastXor  = parAccQ ^ shiftQ[0];
    startOk  = BaudTick & ~FifoEmpty & (~CtsEn | ~ctsSyncQ) & ~BreakReq;
    bitEnd   = BaudTick & (timerQ == '0);

    if (!TxEn) begin
      stateD  = StIdle;
      timerD  = '0;
      bitCntD = '0;
      txdD    = 1'b1;
    end else begin
      if (BaudTick && timerQ != '0) timerD = timerQ - 1'b1;
      unique case (stateQ)
        StIdle: begin
          if (BreakReq) begin
            stateD = StBreak;
            txdD   = 1'b0;
          end else if (startOk) begin
            launch = 1'b1;
          end
        end
        StStart: begin
          if (bitEnd) begin
            stateD  = StData;
            timerD  = BitLoad;
            bitCntD = '0;
            txdD    = shiftQ[0];
          end
        end
        StData: begin
          if (bitEnd) begin
            parAccD = lastXor;
            shiftD  = shiftQ >> 1;
            timerD  = BitLoad;
            if (bitCntQ == cfgBitsQ - 4'd1) begin
              if (parityEnabled(cfgParQ)) begin
                stateD = StParity;
                txdD   = parityBit(cfgParQ, lastXor);
              end else begin
                stateD = StStop;
                timerD = stopLoad;
                txdD   = 1'b1;
              end
            end else begin
              bitCntD = bitCntQ + 4'd1;
              txdD    = shiftQ[1];
            end
          end
        end
        StParity: begin
          if (bitEnd) begin
            stateD = StStop;
            timerD = stopLoad;
            txdD   = 1'b1;
          end
        end
        StStop: begin
          if (bitEnd) begin
            doneD = 1'b1;
            if (BreakReq) begin
              stateD = StBreak;
              txdD   = 1'b0;
            end else if (startOk) begin
              launch = 1'b1;
            end else begin
              stateD = StIdle;
              txdD   = 1'b1;
            end
          end
        end
        StBreak: begin
          if (!BreakReq) begin
            stateD = StBrkStop;
            timerD = BitLoad;
            txdD   = 1'b1;
          end
        end
        StBrkStop: begin
          if (bitEnd) stateD = StIdle;
        end
        default: begin
          stateD = StIdle;
          txdD   = 1'b1;
        end
      endcase

      // Frame start from IDLE or back-to-back from STOP: format is frozen here.
      if (launch) begin
        fifoPop  = 1'b1;
        shiftD   = fifoRdData;
        cfgBitsD = decodeDataBits(DataBits);
        cfgParD  = parityEnabled(Parity) ? Parity : PAR_NONE;
        cfgStopD = StopBits;
        stateD   = StStart;
        timerD   = BitLoad;
        bitCntD  = '0;
        parAccD  = 1'b0;
        txdD     = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stateQ   <= StIdle;
      timerQ   <= '0;
      bitCntQ  <= '0;
      shiftQ   <= '0;
      parAccQ  <= 1'b0;
      cfgBitsQ <= 4'd8;
      cfgParQ  <= PAR_NONE;
      cfgStopQ <= STOP_ONE;
      txdQ     <= 1'b1;
      doneQ    <= 1'b0;
      ctsMetaQ <= 1'b1;
      ctsSyncQ <= 1'b1;
    end else begin
      stateQ   <= stateD;
      timerQ   <= timerD;
      bitCntQ  <= bitCntD;
      shiftQ   <= shiftD;
      parAccQ  <= parAccD;
      cfgBitsQ <= cfgBitsD;
      cfgParQ  <= cfgParD;
      cfgStopQ <= cfgStopD;
      txdQ     <= txdD;
      doneQ    <= doneD;
      ctsMetaQ <= CTSn;
      ctsSyncQ <= ctsMetaQ;
    end
  end

  assign TXD    = txdQ;
  assign TxBusy = (stateQ != StIdle);
  assign TxDone = doneQ;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
module tb_uart_tx_fifo_ctrl;

  localparam int unsigned OSR        = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DW         = 9;
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          BaudTick = 1'b0;
  logic          TxEn = 1'b0;
  logic [3:0]    DataBits = 4'd8;
  logic [2:0]    Parity = 3'd0;
  logic [1:0]    StopBits = 2'd0;
  logic          CtsEn = 1'b0;
  logic          CTSn = 1'b1;
  logic          BreakReq = 1'b0;
  logic          WrEn = 1'b0;
  logic [DW-1:0] WrData = '0;
  logic          FifoClr = 1'b0;
  logic          FifoFull, FifoEmpty, Overflow, TXD, TxBusy, TxDone;
  logic [LW-1:0] FifoLevel;

  uart_tx_fifo_ctrl #(
    .OSR        (OSR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DW         (DW)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .BaudTick  (BaudTick),
    .TxEn      (TxEn),
    .DataBits  (DataBits),
    .Parity    (Parity),
    .StopBits  (StopBits),
    .CtsEn     (CtsEn),
    .CTSn      (CTSn),
    .BreakReq  (BreakReq),
    .WrEn      (WrEn),
    .WrData    (WrData),
    .FifoClr   (FifoClr),
    .FifoFull  (FifoFull),
    .FifoEmpty (FifoEmpty),
    .FifoLevel (FifoLevel),
    .Overflow  (Overflow),
    .TXD       (TXD),
    .TxBusy    (TxBusy),
    .TxDone    (TxDone)
  );

  always #5 CLK = ~CLK;

  // BaudTick every third CLK, changed just after the rising edge.
  int tickDiv = 0;
  always begin
    @(posedge CLK);
    #1;
    tickDiv  = (tickDiv == 2) ? 0 : tickDiv + 1;
    BaudTick = (tickDiv == 2);
  end

  // TXD as seen by each tick, and a count of TxDone pulses.
  logic tickLog[$];
  int   doneCnt = 0;
  always @(negedge CLK) begin
    if (BaudTick === 1'b1) tickLog.push_back(TXD);
    if (TxDone === 1'b1) doneCnt++;
  end

  int   errors = 0;
  int   checks = 0;
  logic expQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame, one entry per BaudTick, built from the frame rules.
  task automatic addFrame(input logic [DW-1:0] d, input int db, input int par, input int stop);
    int   nb;
    int   ones;
    int   stopTicks;
    logic pb;
    nb   = (db >= 5 && db <= 9) ? db : 8;
    ones = 0;
    repeat (OSR) expQ.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (OSR) expQ.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par >= 1 && par <= 4) begin
      pb = (par == 1) ? ((ones % 2) == 0) : (par == 2) ? ((ones % 2) == 1) : (par == 3);
      repeat (OSR) expQ.push_back(pb);
    end
    stopTicks = (stop == 0) ? OSR : (stop == 1) ? (OSR * 3 / 2) : (2 * OSR);
    repeat (stopTicks) expQ.push_back(1'b1);
  endtask

  task automatic addLevel(input logic v, input int n);
    repeat (n) expQ.push_back(v);
  endtask

  task automatic checkLog(input string tag, input int from);
    int first;
    int mism;
    first = -1;
    mism  = 0;
    for (int i = from; i < tickLog.size(); i++) begin
      if (tickLog[i] === 1'b0) begin
        first = i;
        break;
      end
    end
    if (first < 0) mism = expQ.size();
    else begin
      for (int k = 0; k < expQ.size(); k++) begin
        if (first + k >= tickLog.size()) mism++;
        else if (tickLog[first + k] !== expQ[k]) mism++;
      end
    end
    check(tag, mism, 0);
  endtask

  task automatic waitTicks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(negedge CLK);
      if (BaudTick === 1'b1) k++;
    end
  endtask

  task automatic waitDone(input string tag, input int target, input int maxCyc);
    int c;
    c = 0;
    while (doneCnt < target && c < maxCyc) begin
      @(negedge CLK);
      c++;
    end
    check({tag, "-timeout"}, (c >= maxCyc), 0);
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic writeByte(input logic [DW-1:0] d);
    WrData = d;
    WrEn   = 1'b1;
    @(negedge CLK);
    WrEn   = 1'b0;
  endtask

  int            base;
  int            ls;
  int            c;
  int            n;
  int            db, par, stp;
  logic [DW-1:0] d;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    check("rst-txd", TXD, 1);
    check("rst-busy", TxBusy, 0);
    check("rst-done", TxDone, 0);
    check("rst-ovf", Overflow, 0);
    check("rst-empty", FifoEmpty, 1);
    check("rst-full", FifoFull, 0);
    check("rst-level", FifoLevel, 0);
    RESETn = 1'b1;
    repeat (3) @(negedge CLK);

    // 8N1, 0xA5
    DataBits = 4'd8; Parity = 3'd0; StopBits = 2'd0; TxEn = 1'b1;
    base = doneCnt; ls = tickLog.size();
    expQ.delete(); addFrame(9'h0A5, 8, 0, 0); addLevel(1'b1, 4);
    writeByte(9'h0A5);
    check("8n1-level", FifoLevel, 1);
    check("8n1-empty", FifoEmpty, 0);
    waitDone("8n1", base + 1, 2000);
    waitTicks(6);
    checkLog("8n1-txd", ls);
    check("8n1-donecnt", doneCnt - base, 1);
    check("8n1-busy", TxBusy, 0);

    // 7O2, 0x41
    DataBits = 4'd7; Parity = 3'd1; StopBits = 2'd2;
    base = doneCnt; ls = tickLog.size();
    expQ.delete(); addFrame(9'h041, 7, 1, 2); addLevel(1'b1, 4);
    writeByte(9'h041);
    waitDone("7o2", base + 1, 2000);
    waitTicks(6);
    checkLog("7o2-txd", ls);
    check("7o2-donecnt", doneCnt - base, 1);
    check("7o2-busy", TxBusy, 0);

    // Fill with transmitter off, overflow on the 17th write, then drain back-to-back
    TxEn = 1'b0;
    db = $urandom_range(0, 15); par = $urandom_range(0, 7); stp = $urandom_range(0, 3);
    DataBits = 4'(db); Parity = 3'(par); StopBits = 2'(stp);
    expQ.delete();
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom);
      addFrame(d, db, par, stp);
      writeByte(d);
    end
    addLevel(1'b1, 4);
    check("fill-level", FifoLevel, 16);
    check("fill-full", FifoFull, 1);
    writeByte(DW'($urandom));
    check("ovf-pulse", Overflow, 1);
    check("ovf-level", FifoLevel, 16);
    @(negedge CLK);
    check("ovf-single", Overflow, 0);
    base = doneCnt; ls = tickLog.size();
    TxEn = 1'b1;
    waitDone("b2b", base + 16, 15000);
    waitTicks(6);
    checkLog("b2b-txd", ls);
    check("b2b-donecnt", doneCnt - base, 16);
    check("b2b-empty", FifoEmpty, 1);

    // Flush overrides a same-cycle write
    TxEn = 1'b0;
    repeat (3) writeByte(DW'($urandom));
    check("clr-pre-level", FifoLevel, 3);
    FifoClr = 1'b1; WrEn = 1'b1; WrData = 9'h1FF;
    @(negedge CLK);
    FifoClr = 1'b0; WrEn = 1'b0;
    check("clr-level", FifoLevel, 0);
    check("clr-empty", FifoEmpty, 1);
    check("clr-ovf", Overflow, 0);

    // CTS gating
    DataBits = 4'd8; Parity = 3'd0; StopBits = 2'd0;
    CtsEn = 1'b1; CTSn = 1'b1; TxEn = 1'b1;
    base = doneCnt; ls = tickLog.size();
    d = DW'($urandom);
    expQ.delete(); addFrame(d, 8, 0, 0); addLevel(1'b1, 4);
    writeByte(d);
    waitTicks(3 * OSR);
    check("cts-hold-busy", TxBusy, 0);
    check("cts-hold-txd", TXD, 1);
    check("cts-hold-level", FifoLevel, 1);
    CTSn = 1'b0;
    c = 0;
    while (TXD !== 1'b0 && c < 40) begin
      @(negedge CLK);
      c++;
    end
    check("cts-latency-ok", (c <= 6), 1);
    waitTicks(3 * OSR);
    CTSn = 1'b1;
    waitDone("cts", base + 1, 2000);
    waitTicks(6);
    checkLog("cts-txd", ls);
    check("cts-donecnt", doneCnt - base, 1);
    CtsEn = 1'b0;

    // Break held 40 ticks from IDLE
    ls = tickLog.size();
    expQ.delete(); addLevel(1'b0, 40); addLevel(1'b1, OSR + 4);
    do @(negedge CLK); while (BaudTick !== 1'b1);
    BreakReq = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge CLK);
      if (BaudTick === 1'b1) n++;
    end
    BreakReq = 1'b0;
    check("brk-busy", TxBusy, 1);
    n = 0; c = 0;
    while (TxBusy !== 1'b0 && c < 500) begin
      @(negedge CLK);
      c++;
      if (BaudTick === 1'b1 && TxBusy === 1'b1) n++;
    end
    check("brk-stop-ticks", n, OSR);
    waitTicks(6);
    checkLog("brk-txd", ls);

    // Disable mid-DATA
    TxEn = 1'b0;
    repeat (2) writeByte(DW'($urandom));
    base = doneCnt;
    TxEn = 1'b1;
    c = 0;
    while (TXD !== 1'b0 && c < 100) begin
      @(negedge CLK);
      c++;
    end
    check("dis-start-timeout", (c >= 100), 0);
    waitTicks(OSR + 5);
    TxEn = 1'b0;
    @(negedge CLK);
    check("dis-txd", TXD, 1);
    check("dis-busy", TxBusy, 0);
    check("dis-level", FifoLevel, 1);
    waitTicks(3 * OSR);
    check("dis-nodone", doneCnt - base, 0);
    FifoClr = 1'b1;
    @(negedge CLK);
    FifoClr = 1'b0;

    // Random formats; settings scrambled once the frame is under way
    TxEn = 1'b1;
    for (int r = 0; r < 6; r++) begin
      db = $urandom_range(0, 15); par = $urandom_range(0, 7); stp = $urandom_range(0, 3);
      DataBits = 4'(db); Parity = 3'(par); StopBits = 2'(stp);
      d = DW'($urandom);
      base = doneCnt; ls = tickLog.size();
      expQ.delete(); addFrame(d, db, par, stp); addLevel(1'b1, 4);
      writeByte(d);
      c = 0;
      while (TxBusy !== 1'b1 && c < 100) begin
        @(negedge CLK);
        c++;
      end
      DataBits = 4'($urandom); Parity = 3'($urandom); StopBits = 2'($urandom);
      waitDone($sformatf("rnd%0d", r), base + 1, 2000);
      waitTicks(6);
      checkLog($sformatf("rnd%0d-txd", r), ls);
      check($sformatf("rnd%0d-donecnt", r), doneCnt - base, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
